// File: rtl/mem_arbiter.sv
// Shares one single-port, fixed-latency memory between the fetch and data ports, round-robin by default.
// Define MEM_ARB_DATA_PRIO_EN to give the data port fixed priority instead.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              halt,
  output logic              idle,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  logic               grant_ok;
  logic               rd_push;
  logic [MEM_LAT-1:0] fl_valid;
  logic [MEM_LAT-1:0] fl_port;

  // Grants are combinational, so they are also gated by reset to keep them low while RST_N is asserted.
  assign grant_ok = RST_N & ~halt;

`ifdef MEM_ARB_DATA_PRIO_EN
  assign d_gnt  = grant_ok & d_req;
  assign if_gnt = grant_ok & if_req & ~d_req;
`else
  logic last;

  assign if_gnt = grant_ok & if_req & (~d_req | (last == PORT_D));
  assign d_gnt  = grant_ok & d_req & (~if_req | (last == PORT_IF));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last <= PORT_D;
    end else if (if_gnt) begin
      last <= PORT_IF;
    end else if (d_gnt) begin
      last <= PORT_D;
    end
  end
`endif

  assign mem_en    = if_gnt | d_gnt;
  assign mem_we    = d_gnt & d_we;
  assign mem_addr  = d_gnt ? d_addr : if_addr;
  assign mem_wdata = d_gnt ? d_wdata : '0;

  // In-flight reads: stage 0 is the newest grant, stage MEM_LAT-1 lines up with mem_rdata.
  assign rd_push = if_gnt | (d_gnt & ~d_we);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fl_valid <= '0;
      fl_port  <= '0;
    end else begin
      fl_valid[0] <= rd_push;
      fl_port[0]  <= d_gnt;
      for (int i = 1; i < MEM_LAT; i++) begin
        fl_valid[i] <= fl_valid[i-1];
        fl_port[i]  <= fl_port[i-1];
      end
    end
  end

  assign if_rvalid = fl_valid[MEM_LAT-1] & (fl_port[MEM_LAT-1] == PORT_IF);
  assign d_rvalid  = fl_valid[MEM_LAT-1] & (fl_port[MEM_LAT-1] == PORT_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  assign idle = RST_N & halt & ~(|fl_valid);

endmodule
